core_mem_arb: RTL and testbench

- Arbitrates the core's L1I fetch port and L1D load/store port onto one shared memory bus.
- Used when both ports miss to the uncore, or in cacheless configurations.
- Sits between the core pipeline request/ack interfaces and the single downstream bus master port.
- Two-way round-robin, one transaction outstanding at a time; read data is routed back to the originating port.

---
 rtl/core_mem_arb_pkg.sv | 33 +++
 rtl/core_rr_arb2.sv | 19 +
 rtl/core_mem_arb.sv | 153 +++++++++++++++
 tb/tb_core_mem_arb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_arb_pkg.sv
// Shared definitions for the core memory arbiter: FSM state encoding, request
// source IDs, the fixed fetch operation codes and the registered bus request layout.
package core_defines;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_WAIT = ST_WAIT,
      S_RESP = ST_RESP
   } arb_state_t;

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;

   localparam logic [2:0] COP_READ  = 3'd0;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef struct packed {
      logic        src;
      logic [31:0] addr;
      logic [2:0]  cop;
      logic [31:0] wdata;
      logic [2:0]  size;
   } bus_req_t;

endpackage

// File: rtl/core_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the L1I port, bit 1 the L1D port;
// ptr names the port that wins when both request.
module core_rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/core_mem_arb.sv
// L1I/L1D to shared memory bus arbiter, one transaction in flight.
// Optional watchdog enabled by defining CORE_MEM_ARB_TIMEOUT_EN.
module core_mem_arb
   import core_defines::*;
#(
   parameter int RST_PRIO    = 0,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_val,
   input  logic [31:0] i_req_addr,
   output logic        i_ack,
   output logic [31:0] i_ack_rdata,
   input  logic        d_req_val,
   input  logic [31:0] d_req_addr,
   input  logic [2:0]  d_req_cop,
   input  logic [31:0] d_req_wdata,
   input  logic [2:0]  d_req_size,
   output logic        d_ack,
   output logic [31:0] d_ack_rdata,
   output logic        bus_req_val,
   input  logic        bus_req_rdy,
   output logic        bus_req_src,
   output logic [31:0] bus_req_addr,
   output logic [2:0]  bus_req_cop,
   output logic [31:0] bus_req_wdata,
   output logic [2:0]  bus_req_size,
   input  logic        bus_ack,
   input  logic [31:0] bus_ack_rdata,
   output logic        arb_err,
   output logic [1:0]  dbg_state,
   output logic        dbg_ptr
);

   localparam logic PTR_RST = (RST_PRIO != 0);

   // Bus handshake: a request is transferred on the cycle where bus_req_val and
   // bus_req_rdy are both high; fields are held stable from val until that cycle.
   arb_state_t  state;
   logic        ptr;
   bus_req_t    req_q;
   logic [1:0]  grant;
   logic        ack_take;
   logic        to_hit;
   logic        done;
   logic [31:0] resp_data;

   core_rr_arb2 u_rr (
      .req   ({d_req_val, i_req_val}),
      .ptr   (ptr),
      .grant (grant)
   );

   // A bus ack counts in WAIT, or in REQ only together with the accepting rdy.
   assign ack_take  = bus_ack && (((state == S_REQ) && bus_req_rdy) || (state == S_WAIT));
   assign done      = ack_take || to_hit;
   assign resp_data = ack_take ? bus_ack_rdata : TIMEOUT_RDATA;

`ifdef CORE_MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] to_cnt;

   // A real ack in the expiring cycle wins over the watchdog.
   assign to_hit = ((state == S_REQ) || (state == S_WAIT)) && (to_cnt == CNT_LAST) && !ack_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt  <= '0;
         arb_err <= 1'b0;
      end else begin
         arb_err <= to_hit;
         if (state == S_IDLE) begin
            to_cnt <= '0;
         end else if ((state == S_REQ) || (state == S_WAIT)) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign to_hit         = 1'b0;
   assign arb_err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ptr         <= PTR_RST;
         req_q       <= '0;
         bus_req_val <= 1'b0;
         i_ack       <= 1'b0;
         d_ack       <= 1'b0;
         i_ack_rdata <= '0;
         d_ack_rdata <= '0;
      end else begin
         i_ack       <= 1'b0;
         d_ack       <= 1'b0;
         i_ack_rdata <= '0;
         d_ack_rdata <= '0;
         case (state)
            S_IDLE: begin
               if (grant != 2'b00) begin
                  state       <= S_REQ;
                  bus_req_val <= 1'b1;
                  if (grant[SRC_D]) begin
                     req_q <= '{src: SRC_D, addr: d_req_addr, cop: d_req_cop,
                                wdata: d_req_wdata, size: d_req_size};
                  end else begin
                     req_q <= '{src: SRC_I, addr: i_req_addr, cop: COP_READ,
                                wdata: 32'h0, size: SIZE_WORD};
                  end
               end
            end
            S_REQ, S_WAIT: begin
               if ((state == S_REQ) && bus_req_rdy) begin
                  bus_req_val <= 1'b0;
                  state       <= S_WAIT;
               end
               if (done) begin
                  state       <= S_RESP;
                  bus_req_val <= 1'b0;
                  if (req_q.src == SRC_D) begin
                     d_ack       <= 1'b1;
                     d_ack_rdata <= resp_data;
                  end else begin
                     i_ack       <= 1'b1;
                     i_ack_rdata <= resp_data;
                  end
               end
            end
            S_RESP: begin
               // The port just served yields to the other one next time.
               ptr   <= ~req_q.src;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus_req_src   = req_q.src;
   assign bus_req_addr  = req_q.addr;
   assign bus_req_cop   = req_q.cop;
   assign bus_req_wdata = req_q.wdata;
   assign bus_req_size  = req_q.size;
   assign dbg_state     = state;
   assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed bench for core_mem_arb with a transaction-level arbitration model and
// a per-cycle compare process; CORE_MEM_ARB_TIMEOUT_EN adds the watchdog test.
module tb_core_mem_arb;
   import core_defines::*;

   localparam int TO_CYC = 8;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
   localparam int STALL_CYC = 6;
`else
   localparam int STALL_CYC = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_val = 1'b0;
   logic [31:0] i_req_addr = '0;
   logic        d_req_val = 1'b0;
   logic [31:0] d_req_addr = '0;
   logic [2:0]  d_req_cop = '0;
   logic [31:0] d_req_wdata = '0;
   logic [2:0]  d_req_size = '0;
   logic        bus_req_rdy = 1'b0;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_ack_rdata = '0;
   logic        i_ack, d_ack, bus_req_val, bus_req_src, arb_err, dbg_ptr;
   logic [31:0] i_ack_rdata, d_ack_rdata, bus_req_addr, bus_req_wdata;
   logic [2:0]  bus_req_cop, bus_req_size;
   logic [1:0]  dbg_state;

   core_mem_arb #(.RST_PRIO(0), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_ack(i_ack), .i_ack_rdata(i_ack_rdata),
      .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
      .d_req_wdata(d_req_wdata), .d_req_size(d_req_size), .d_ack(d_ack), .d_ack_rdata(d_ack_rdata),
      .bus_req_val(bus_req_val), .bus_req_rdy(bus_req_rdy), .bus_req_src(bus_req_src),
      .bus_req_addr(bus_req_addr), .bus_req_cop(bus_req_cop), .bus_req_wdata(bus_req_wdata),
      .bus_req_size(bus_req_size), .bus_ack(bus_ack), .bus_ack_rdata(bus_ack_rdata),
      .arb_err(arb_err), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
   );

   // clock/reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event want event within budget", name);
   endtask

   function automatic logic [159:0] all_outputs();
      return {18'b0, i_ack, i_ack_rdata, d_ack, d_ack_rdata, bus_req_val, bus_req_src,
              bus_req_addr, bus_req_cop, bus_req_wdata, bus_req_size, arb_err, dbg_state, dbg_ptr};
   endfunction

   // scoreboard / model
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   bus_req_t    snap_i, snap_d, exp_req;
   logic        snap_iv = 1'b0, snap_dv = 1'b0;
   logic        model_ptr = 1'b0;
   logic        in_txn = 1'b0;
   logic        cur_port = 1'b0;
   logic        prev_bus_val = 1'b0;
   logic [31:0] e_data;
   logic        e_err;
   int          i_ack_cnt = 0;
   int          d_ack_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_outputs", all_outputs(), '0);
         in_txn       = 1'b0;
         prev_bus_val = 1'b0;
         model_ptr    = 1'b0;
         exp_q.delete();
         exp_err_q.delete();
      end else begin
         if (i_ack) i_ack_cnt++;
         if (d_ack) d_ack_cnt++;
         if (i_ack || d_ack) begin
            check("single_ack", i_ack & d_ack, 1'b0);
            if (!in_txn || exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b want no ack", i_ack, d_ack);
            end else begin
               e_data = exp_q.pop_front();
               e_err  = exp_err_q.pop_front();
               check("ack_port", d_ack, cur_port);
               check("ack_rdata", cur_port ? d_ack_rdata : i_ack_rdata, e_data);
               check("ack_arb_err", arb_err, e_err);
               model_ptr = ~cur_port;
               in_txn    = 1'b0;
            end
         end else begin
            check("arb_err_quiet", arb_err, 1'b0);
         end
         if (!i_ack) check("i_rdata_idle", i_ack_rdata, '0);
         if (!d_ack) check("d_rdata_idle", d_ack_rdata, '0);
         if (bus_req_val && !prev_bus_val && !in_txn) begin
            check("ptr_at_grant", dbg_ptr, model_ptr);
            if (!snap_iv && !snap_dv) begin
               checks++;
               errors++;
               $display("FAIL spurious_grant: got bus_req_val=1 want 0");
            end
            if (snap_iv && snap_dv) cur_port = model_ptr;
            else if (snap_dv)       cur_port = SRC_D;
            else                    cur_port = SRC_I;
            exp_req = (cur_port == SRC_D) ? snap_d : snap_i;
            in_txn  = 1'b1;
         end
         if (bus_req_val)
            check("bus_req_fields", {bus_req_src, bus_req_addr, bus_req_cop, bus_req_wdata, bus_req_size}, exp_req);
         prev_bus_val = bus_req_val;
      end
      snap_iv = i_req_val;
      snap_dv = d_req_val;
      snap_i  = '{src: SRC_I, addr: i_req_addr, cop: COP_READ, wdata: 32'h0, size: SIZE_WORD};
      snap_d  = '{src: SRC_D, addr: d_req_addr, cop: d_req_cop, wdata: d_req_wdata, size: d_req_size};
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_req_val = 1'b0; d_req_val = 1'b0;
      bus_req_rdy = 1'b0; bus_ack = 1'b0; bus_ack_rdata = '0;
      tick(2);
      check("reset_state_ptr", {dbg_state, dbg_ptr}, 3'b000);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic request(input logic port, input logic [31:0] addr, input logic [2:0] cop,
                          input logic [31:0] wdata, input logic [2:0] size, output logic [31:0] rdata);
      int n;
      logic got;
      n = 0;
      got = 1'b0;
      rdata = '0;
      if (port == SRC_D) begin
         d_req_val = 1'b1; d_req_addr = addr; d_req_cop = cop; d_req_wdata = wdata; d_req_size = size;
      end else begin
         i_req_val = 1'b1; i_req_addr = addr;
      end
      while (!got && n < 100) begin
         tick(1);
         n++;
         got = (port == SRC_D) ? d_ack : i_ack;
      end
      if (!got) fail_evt("ack_wait");
      else rdata = (port == SRC_D) ? d_ack_rdata : i_ack_rdata;
      tick(1);
      if (port == SRC_D) d_req_val = 1'b0;
      else i_req_val = 1'b0;
   endtask

   task automatic serve_bus(input int rdy_dly, input int ack_dly, input logic [31:0] data,
                            output logic src, output logic [31:0] wdata);
      int n;
      n = 0;
      src = 1'b0;
      wdata = '0;
      while (!bus_req_val && n < 50) begin
         tick(1);
         n++;
      end
      if (!bus_req_val) begin
         fail_evt("bus_req_wait");
         return;
      end
      src = bus_req_src;
      wdata = bus_req_wdata;
      repeat (rdy_dly) tick(1);
      check("req_held", bus_req_val, 1'b1);
      bus_req_rdy = 1'b1;
      if (ack_dly == 0) begin
         bus_ack = 1'b1; bus_ack_rdata = data;
         exp_q.push_back(data); exp_err_q.push_back(1'b0);
      end
      tick(1);
      bus_req_rdy = 1'b0; bus_ack = 1'b0; bus_ack_rdata = '0;
      if (ack_dly > 0) begin
         repeat (ack_dly - 1) tick(1);
         bus_ack = 1'b1; bus_ack_rdata = data;
         exp_q.push_back(data); exp_err_q.push_back(1'b0);
         tick(1);
         bus_ack = 1'b0; bus_ack_rdata = '0;
      end
   endtask

   logic [31:0] rd_i, rd_d, w0, w1;
   logic        s0, s1;
   logic        srcs[$];
   logic [5:0]  exp_pat;
   int          wait_n, cyc, cnt_before;

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL global_timeout: got no finish want finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      do_reset();

      // single fetch, rdy at once, ack two cycles after rdy
      fork
         request(SRC_I, 32'h0000_0100, 3'd0, 32'h0, 3'd0, rd_i);
         serve_bus(0, 2, 32'h0000_0013, s0, w0);
      join
      check("t1_src", s0, 1'b0);
      check("t1_rdata", rd_i, 32'h0000_0013);
      check("t1_i_ack_cycles", i_ack_cnt, 1);
      check("t1_d_ack_none", d_ack_cnt, 0);

      // simultaneous requests after reset: I first, then the D store
      do_reset();
      fork
         request(SRC_I, 32'h0000_0200, 3'd0, 32'h0, 3'd0, rd_i);
         request(SRC_D, 32'h8000_0000, 3'd1, 32'hCAFE_F00D, 3'd2, rd_d);
         begin
            serve_bus(0, 1, 32'h0000_0AAA, s0, w0);
            serve_bus(1, 0, 32'h0000_0000, s1, w1);
         end
      join
      check("t2_first_src", s0, 1'b0);
      check("t2_second_src", s1, 1'b1);
      check("t2_store_wdata", w1, 32'hCAFE_F00D);
      check("t2_fetch_rdata", rd_i, 32'h0000_0AAA);
      check("t2_ptr_back_to_i", dbg_ptr, 1'b0);

      // both ports continuously busy: strict alternation
      srcs.delete();
      fork
         for (int k = 0; k < 3; k++) request(SRC_I, 32'h0000_1000 + 32'(k * 4), 3'd0, 32'h0, 3'd0, rd_i);
         for (int k = 0; k < 3; k++) request(SRC_D, 32'h0000_2000 + 32'(k * 4), 3'd0, 32'h0, 3'd2, rd_d);
         for (int k = 0; k < 6; k++) begin
            serve_bus(k % 2, k % 3, 32'h0000_3000 + 32'(k), s0, w0);
            srcs.push_back(s0);
         end
      join
      exp_pat = 6'b101010;
      check("t3_grant_count", srcs.size(), 6);
      for (int k = 0; k < 6 && k < srcs.size(); k++) check("t3_grant_order", srcs[k], exp_pat[k]);

      // long rdy stall: fields held, no ack until accepted
      cnt_before = i_ack_cnt;
      fork
         request(SRC_I, 32'h0000_0400, 3'd0, 32'h0, 3'd0, rd_i);
         begin
            serve_bus(STALL_CYC, 1, 32'h1234_5678, s0, w0);
         end
      join
      check("t4_rdata", rd_i, 32'h1234_5678);
      check("t4_single_ack", i_ack_cnt - cnt_before, 1);

      // asynchronous reset while waiting for the bus ack
      i_req_val = 1'b1; i_req_addr = 32'h0000_0500;
      wait_n = 0;
      while (!bus_req_val && wait_n < 50) begin tick(1); wait_n++; end
      check("t5_req_seen", bus_req_val, 1'b1);
      bus_req_rdy = 1'b1;
      tick(1);
      bus_req_rdy = 1'b0;
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_clear", all_outputs(), '0);
      i_req_val = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(1);
      srcs.delete();
      fork
         request(SRC_I, 32'h0000_0600, 3'd0, 32'h0, 3'd0, rd_i);
         request(SRC_D, 32'h0000_0604, 3'd0, 32'h0, 3'd2, rd_d);
         for (int k = 0; k < 2; k++) begin
            serve_bus(0, 1, 32'h0000_0060 + 32'(k), s0, w0);
            srcs.push_back(s0);
         end
      join
      check("t5_prio_after_reset", (srcs.size() > 0) ? srcs[0] : 1'b1, 1'b0);

`ifdef CORE_MEM_ARB_TIMEOUT_EN
      // watchdog: bus accepts but never acks
      do_reset();
      exp_q.push_back(32'hDEAD_BEEF);
      exp_err_q.push_back(1'b1);
      fork
         request(SRC_I, 32'h0000_0700, 3'd0, 32'h0, 3'd0, rd_i);
         begin
            wait_n = 0;
            while (!bus_req_val && wait_n < 50) begin tick(1); wait_n++; end
            bus_req_rdy = 1'b1;
            cyc = 0;
            while (!i_ack && cyc < 40) begin
               tick(1);
               bus_req_rdy = 1'b0;
               cyc++;
            end
            check("t6_timeout_cycles", cyc, 8);
            check("t6_arb_err", arb_err, 1'b1);
         end
      join
      check("t6_rdata", rd_i, 32'hDEAD_BEEF);
      cnt_before = i_ack_cnt;
      bus_ack = 1'b1; bus_ack_rdata = 32'h5555_5555;
      tick(1);
      bus_ack = 1'b0; bus_ack_rdata = '0;
      tick(3);
      check("t6_stale_ack_ignored", i_ack_cnt, cnt_before);
`endif

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
